serial_mag_comparator: RTL
==========================

Name: serial_mag_comparator

Overview:
- Bit-serial magnitude comparator that receives two WIDTH-bit operands one bit pair per handshake, MSB first, and reports A>B, A<B or A=B.
- Low-power counterpart to the parallel NAND-based comparator datapath: one bit-cell of decision logic is reused over WIDTH cycles instead of WIDTH parallel cells.
- Sits downstream of an operand serializer and feeds the comparator result to the host logic.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a comparison; honoured only in IDLE.
- a_bit  input  1  current bit of operand A (MSB first).
- b_bit  input  1  current bit of operand B (MSB first).
- bit_valid  input  1  upstream has a valid a_bit/b_bit pair.
- bit_ready  output  1  block accepts the pair this cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when the result is final.
- a_gt_b  output  1  registered result, held until next start.
- a_lt_b  output  1  registered result, held until next start.
- a_eq_b  output  1  registered result, held until next start.

Behaviour:
- Reset (async, any state): state=IDLE, count=0, bit_ready=0, busy=0, done=0, a_gt_b=a_lt_b=a_eq_b=0. An in-flight comparison is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: bit_ready=0. On start=1, go to SHIFT next cycle, clear count, internal gt/lt, and all three result outputs.
- SHIFT: bit_ready=1. A transfer occurs when bit_valid and bit_ready are both 1.
  - On a transfer while gt=lt=0: a_bit=1 and b_bit=0 sets gt; a_bit=0 and b_bit=1 sets lt.
  - Once gt or lt is set it is sticky; later bits are ignored for the decision.
  - count increments on each transfer.
  - The transfer with count==WIDTH-1 moves the block to DONE.
  - bit_valid=0 stalls with no change in state.
- DONE (one cycle): done=1. Outputs are loaded as a_gt_b=gt, a_lt_b=lt, a_eq_b=~gt&~lt. Next state is IDLE.
- Latency: done is asserted the cycle after the final transfer. Minimum start-to-done time is WIDTH+2 cycles.
- Exactly one of a_gt_b, a_lt_b, a_eq_b is 1 after any completed comparison. All three are 0 between start and done.
- start in SHIFT or DONE is ignored. A start coincident with the DONE cycle is also ignored.
- A bit pair presented while bit_ready=0 is not consumed.
- Counter wrap is not reachable: the count resets on every start.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_DONE_EN.
- Defined: the first differing bit pair moves SHIFT to DONE immediately, and bit_ready drops the next cycle. The upstream serializer discards any unsent bits, and the saved cycles give the power reduction. Equal operands still take all WIDTH transfers.
- Undefined: exactly WIDTH transfers occur per comparison, regardless of when the decision is made.

Decomposition:
- Package serial_cmp_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - result encoding constants (RES_EQ, RES_GT, RES_LT);
  - the WIDTH range-check constants.
- One natural sub-module, cmp_bit_cell: combinational next gt/lt from the current gt/lt and a_bit/b_bit. Its structure mirrors the gate-level comparator cell so that both can be checked against the same truth table.

Test Plan:
- A=1010, B=0110, bit_valid held 1 -> gt set on bit 3. done arrives 6 cycles after start with a_gt_b=1, a_lt_b=0, a_eq_b=0. With EARLY_DONE_EN: done after the first transfer, only 1 transfer consumed.
- A=0011, B=0101 with bit_valid=0 on alternate cycles -> stalls do not advance count; a_lt_b=1 after exactly 4 transfers.
- A=B=1001 -> a_eq_b=1, all 4 transfers consumed under both macro settings.
- rst pulsed after 2 transfers of A=1111, B=0000 -> all outputs 0, state IDLE, no done pulse. A following start with A=0000, B=0000 yields a_eq_b=1.
- start pulsed during SHIFT and during the DONE cycle -> ignored, result unaffected. Back-to-back start in the cycle after DONE is accepted.
- Exhaustive sweep: all 256 (A,B) pairs at WIDTH=4 -> exactly one result flag set per comparison, matching the reference integer compare.

Source files
------------

// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Optional build macro: SERIAL_CMP_EARLY_DONE_EN (early completion on first differing bit).
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic logic [1:0] cmp_result(input logic gt, input logic lt);
        if (gt)
            return RES_GT;
        else if (lt)
            return RES_LT;
        return RES_EQ;
    endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Bit-pair handshake plus result bus between the operand serializer and the comparator.
interface serial_mag_comparator_if;

    logic start;
    logic a_bit;
    logic b_bit;
    logic bit_valid;
    logic bit_ready;
    logic busy;
    logic done;
    logic a_gt_b;
    logic a_lt_b;
    logic a_eq_b;

    modport master (
        output start, a_bit, b_bit, bit_valid,
        input  bit_ready, busy, done, a_gt_b, a_lt_b, a_eq_b
    );

    modport slave (
        input  start, a_bit, b_bit, bit_valid,
        output bit_ready, busy, done, a_gt_b, a_lt_b, a_eq_b
    );

endinterface

// File: rtl/serial_mag_comparator_bit_cell.sv
// One comparator bit-cell: next gt/lt from the running decision and the current bit pair.
// Written in NAND form so it lines up with the gate-level cell's truth table.
module cmp_bit_cell (
    input  logic gt_in,
    input  logic lt_in,
    input  logic a_bit,
    input  logic b_bit,
    output logic gt_out,
    output logic lt_out
);

    logic n_a_gt;
    logic n_a_lt;
    logic n_undecided;

    // Active-low partial terms, as in the parallel NAND comparator cell.
    assign n_a_gt      = ~(a_bit & ~b_bit);
    assign n_a_lt      = ~(~a_bit & b_bit);
    assign n_undecided = ~(~gt_in & ~lt_in);

    assign gt_out = ~(~gt_in & ~(~n_undecided & ~n_a_gt));
    assign lt_out = ~(~lt_in & ~(~n_undecided & ~n_a_lt));

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator reusing a single bit-cell over WIDTH transfers.
// Optional build macro: SERIAL_CMP_EARLY_DONE_EN (finish on the first differing bit pair).
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_mag_comparator_if.slave  bus
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_mag_comparator: WIDTH out of range");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             bit_ready_q, bit_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_gt_b_q, a_gt_b_d;
    logic             a_lt_b_q, a_lt_b_d;
    logic             a_eq_b_q, a_eq_b_d;

    logic             cell_gt, cell_lt;
    logic             transfer;
    logic             finish;
    logic [1:0]       res_code;

    cmp_bit_cell u_cell (
        .gt_in  (gt_q),
        .lt_in  (lt_q),
        .a_bit  (bus.a_bit),
        .b_bit  (bus.b_bit),
        .gt_out (cell_gt),
        .lt_out (cell_lt)
    );

    assign transfer = (state_q == SHIFT) & bus.bit_valid & bit_ready_q;
    assign res_code = cmp_result(cell_gt, cell_lt);

`ifdef SERIAL_CMP_EARLY_DONE_EN
    assign finish = transfer & ((count_q == LAST) | cell_gt | cell_lt);
`else
    assign finish = transfer & (count_q == LAST);
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        a_gt_b_d = a_gt_b_q;
        a_lt_b_d = a_lt_b_q;
        a_eq_b_d = a_eq_b_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SHIFT;
                    count_d  = '0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    a_gt_b_d = 1'b0;
                    a_lt_b_d = 1'b0;
                    a_eq_b_d = 1'b0;
                end
            end
            SHIFT: begin
                if (transfer) begin
                    gt_d    = cell_gt;
                    lt_d    = cell_lt;
                    count_d = count_q + CNT_W'(1);
                end
                // Results are loaded on the way into DONE so they are valid alongside done.
                if (finish) begin
                    state_d  = DONE;
                    a_gt_b_d = (res_code == RES_GT);
                    a_lt_b_d = (res_code == RES_LT);
                    a_eq_b_d = (res_code == RES_EQ);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bit_ready_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_gt_b_q    <= 1'b0;
            a_lt_b_q    <= 1'b0;
            a_eq_b_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            bit_ready_q <= bit_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            a_gt_b_q    <= a_gt_b_d;
            a_lt_b_q    <= a_lt_b_d;
            a_eq_b_q    <= a_eq_b_d;
        end
    end

    assign bus.bit_ready = bit_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a_gt_b    = a_gt_b_q;
    assign bus.a_lt_b    = a_lt_b_q;
    assign bus.a_eq_b    = a_eq_b_q;

endmodule
